// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multi-cycle fetch/decode/execute/mem/writeback control sequencer
//
// Steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK and
// drives the datapath strobes. Conditional branches read the stored zero and
// parity flags. This block is the only writer of flag_write_enable.
//
// Optional feature macro: CTRL_MEM_WAIT_EN
//   defined   - mem_ready port exists; FETCH and MEM stall until mem_ready=1.
//   undefined - no mem_ready port; every memory access completes in one cycle.
//
// Ports:
//   clk               in  1  clock
//   rst               in  1  asynchronous active-high reset
//   start             in  1  leave IDLE/HALT and begin fetching
//   opcode            in  4  IR opcode field, valid from DECODE onward
//   z_flag, p_flag    in  1  stored zero / parity flags
//   mem_ready         in  1  memory access complete (CTRL_MEM_WAIT_EN only)
//   ir_write          out 1  load IR
//   pc_inc, pc_load   out 1  PC increment / PC branch load
//   reg_write         out 1  register-file write
//   flag_write_enable out 1  flags register update
//   alu_op            out 3  ADD=0 SUB=1 AND=2 OR=3 XOR=4
//   mem_read          out 1  memory read
//   mem_write         out 1  memory write
//   halted            out 1  in HALT
//   illegal_op        out 1  sticky: last decode hit an undefined opcode
//   state             out 3  current state encoding

module control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] opcode,
    input  logic       z_flag,
    input  logic       p_flag,
`ifdef CTRL_MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    output logic       ir_write,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       reg_write,
    output logic       flag_write_enable,
    output logic [2:0] alu_op,
    output logic       mem_read,
    output logic       mem_write,
    output logic       halted,
    output logic       illegal_op,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    state_t r_state;
    logic   r_illegal;

    logic   w_mem_ready;
    logic   w_is_alu;
    logic   w_is_branch;
    logic   w_is_load;
    logic   w_is_store;
    logic   w_is_nop;
    logic   w_is_halt;
    logic   w_taken;

`ifdef CTRL_MEM_WAIT_EN
    assign w_mem_ready = mem_ready;
`else
    assign w_mem_ready = 1'b1;
`endif

    assign w_is_nop    = (opcode == 4'h0);
    assign w_is_alu    = (opcode >= 4'h1) && (opcode <= 4'h5);
    assign w_is_load   = (opcode == 4'h6);
    assign w_is_store  = (opcode == 4'h7);
    assign w_is_branch = (opcode >= 4'h8) && (opcode <= 4'hB);
    assign w_is_halt   = (opcode == 4'hF);

    // Branch condition from the currently stored flags.
    always_comb begin
        w_taken = 1'b0;
        case (opcode)
            4'h8:    w_taken = z_flag;
            4'h9:    w_taken = ~z_flag;
            4'hA:    w_taken = p_flag;
            4'hB:    w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (w_mem_ready) r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (w_is_alu || w_is_branch) begin
                        r_state <= S_EXECUTE;
                    end else if (w_is_load || w_is_store) begin
                        r_state <= S_MEM;
                    end else if (w_is_nop) begin
                        r_state <= S_FETCH;
                    end else if (w_is_halt) begin
                        r_state <= S_HALT;
                    end else begin
                        // C, D, E: undefined opcodes park the sequencer.
                        r_state   <= S_HALT;
                        r_illegal <= 1'b1;
                    end
                end
                S_EXECUTE: begin
                    r_state <= w_is_alu ? S_WRITEBACK : S_FETCH;
                end
                S_MEM: begin
                    if (w_mem_ready) r_state <= w_is_load ? S_WRITEBACK : S_FETCH;
                end
                S_WRITEBACK: begin
                    r_state <= S_FETCH;
                end
                S_HALT: begin
                    if (start) begin
                        r_state   <= S_FETCH;
                        r_illegal <= 1'b0;
                    end
                end
                // Encoding 7 is never entered; recover to IDLE.
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode straight from the registered state, so an asynchronous
    // reset drops them in the same cycle.
    always_comb begin
        ir_write          = 1'b0;
        pc_inc            = 1'b0;
        pc_load           = 1'b0;
        reg_write         = 1'b0;
        flag_write_enable = 1'b0;
        alu_op            = 3'd0;
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = w_mem_ready;
                pc_inc   = w_mem_ready;
            end
            S_EXECUTE: begin
                if (w_is_alu) begin
                    flag_write_enable = 1'b1;
                    case (opcode)
                        4'h1:    alu_op = 3'd0;
                        4'h2:    alu_op = 3'd1;
                        4'h3:    alu_op = 3'd2;
                        4'h4:    alu_op = 3'd3;
                        4'h5:    alu_op = 3'd4;
                        default: alu_op = 3'd0;
                    endcase
                end else if (w_is_branch) begin
                    pc_load = w_taken;
                end
            end
            S_MEM: begin
                mem_read  = w_is_load;
                mem_write = w_is_store;
            end
            S_WRITEBACK: begin
                reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign halted     = (r_state == S_HALT);
    assign illegal_op = r_illegal;
    assign state      = r_state;

endmodule

// File: tb/tb_control_fsm.sv
// tb/tb_control_fsm.sv - scoreboard testbench for control_fsm

module tb_control_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       z_flag = 1'b0;
    logic       p_flag = 1'b0;
    logic       mem_ready = 1'b1;
    logic       ir_write, pc_inc, pc_load, reg_write, flag_write_enable;
    logic [2:0] alu_op;
    logic       mem_read, mem_write, halted, illegal_op;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    logic [14:0] exp_q[$];
    string       lbl_q[$];
    logic [14:0] w_obs;

    always #5 clk = ~clk;

    control_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .opcode            (opcode),
        .z_flag            (z_flag),
        .p_flag            (p_flag),
`ifdef CTRL_MEM_WAIT_EN
        .mem_ready         (mem_ready),
`endif
        .ir_write          (ir_write),
        .pc_inc            (pc_inc),
        .pc_load           (pc_load),
        .reg_write         (reg_write),
        .flag_write_enable (flag_write_enable),
        .alu_op            (alu_op),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .halted            (halted),
        .illegal_op        (illegal_op),
        .state             (state)
    );

    assign w_obs = {state, ir_write, pc_inc, pc_load, reg_write, flag_write_enable,
                    alu_op, mem_read, mem_write, halted, illegal_op};

    // {state, ir, pc_inc, pc_load, reg_wr, flag_we, alu_op, mem_rd, mem_wr, halted, illegal}
    function automatic logic [14:0] mk(input logic [2:0] st, input logic ir, input logic pci,
                                       input logic pcl, input logic rw, input logic fwe,
                                       input logic [2:0] alu, input logic mr, input logic mw,
                                       input logic h, input logic ill);
        return {st, ir, pci, pcl, rw, fwe, alu, mr, mw, h, ill};
    endfunction

    task automatic push(input logic [14:0] v, input string l);
        exp_q.push_back(v);
        lbl_q.push_back(l);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_one();
        logic [14:0] e;
        string       l;
        e = exp_q.pop_front();
        l = lbl_q.pop_front();
        checks++;
        if (w_obs !== e) begin
            errors++;
            $display("FAIL %s: got %b required %b", l, w_obs, e);
        end
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            check_one();
            tick();
        end
    endtask

    // Reference model: expected per-cycle outputs from FETCH to the next FETCH entry.
    task automatic push_instr(input logic [3:0] op, input logic z, input logic p, input string l);
        logic tk;
        opcode = op;
        z_flag = z;
        p_flag = p;
        push(mk(3'd1, 1, 1, 0, 0, 0, 3'd0, 1, 0, 0, 0), {l, ".fetch"});
        push(mk(3'd2, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0), {l, ".decode"});
        if (op >= 4'h1 && op <= 4'h5) begin
            push(mk(3'd3, 0, 0, 0, 0, 1, 3'(op - 4'd1), 0, 0, 0, 0), {l, ".exec"});
            push(mk(3'd5, 0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 0), {l, ".wb"});
        end else if (op >= 4'h8 && op <= 4'hB) begin
            tk = (op == 4'h8) ? z : (op == 4'h9) ? !z : (op == 4'hA) ? p : 1'b1;
            push(mk(3'd3, 0, 0, tk, 0, 0, 3'd0, 0, 0, 0, 0), {l, ".exec"});
        end else if (op == 4'h6) begin
            push(mk(3'd4, 0, 0, 0, 0, 0, 3'd0, 1, 0, 0, 0), {l, ".mem"});
            push(mk(3'd5, 0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 0), {l, ".wb"});
        end else if (op == 4'h7) begin
            push(mk(3'd4, 0, 0, 0, 0, 0, 3'd0, 0, 1, 0, 0), {l, ".mem"});
        end else if (op == 4'hF) begin
            push(mk(3'd6, 0, 0, 0, 0, 0, 3'd0, 0, 0, 1, 0), {l, ".halt"});
        end else if (op >= 4'hC) begin
            push(mk(3'd6, 0, 0, 0, 0, 0, 3'd0, 0, 0, 1, 1), {l, ".halt"});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        push(15'd0, "reset.outputs");
        check_one();
        rst = 1'b0;
        tick();
        push(15'd0, "reset.idle_hold");
        check_one();
    endtask

    task automatic test_alu();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int op = 1; op <= 5; op++) begin
            push_instr(4'(op), 1'b0, 1'b0, $sformatf("alu%0d", op));
            drain();
        end
    endtask

    task automatic test_branch();
        push_instr(4'h8, 1'b1, 1'b0, "bz_z1");  drain();
        push_instr(4'h8, 1'b0, 1'b0, "bz_z0");  drain();
        push_instr(4'h9, 1'b0, 1'b1, "bnz_z0"); drain();
        push_instr(4'h9, 1'b1, 1'b1, "bnz_z1"); drain();
        push_instr(4'hA, 1'b1, 1'b1, "bp_p1");  drain();
        push_instr(4'hA, 1'b1, 1'b0, "bp_p0");  drain();
        push_instr(4'hB, 1'b0, 1'b0, "jmp");    drain();
    endtask

    task automatic test_load_store();
        push_instr(4'h6, 1'b0, 1'b0, "load");  drain();
        push_instr(4'h7, 1'b0, 1'b0, "store"); drain();
    endtask

    task automatic test_back_to_back_start_ignored();
        start = 1'b1;
        push_instr(4'h0, 1'b0, 1'b0, "nop_start"); drain();
        push_instr(4'h2, 1'b0, 1'b0, "sub_start"); drain();
        push_instr(4'h0, 1'b0, 1'b0, "nop2");      drain();
        start = 1'b0;
    endtask

    task automatic restart_from_halt(input logic ill, input string l);
        push(mk(3'd6, 0, 0, 0, 0, 0, 3'd0, 0, 0, 1, ill), {l, ".halt_hold"});
        check_one();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_illegal();
        push_instr(4'hD, 1'b0, 1'b0, "illegal_d");
        drain();
        restart_from_halt(1'b1, "illegal_d");
        push_instr(4'h1, 1'b0, 1'b0, "after_illegal"); drain();
        push_instr(4'hC, 1'b0, 1'b0, "illegal_c");     drain();
        restart_from_halt(1'b1, "illegal_c");
    endtask

    task automatic test_halt();
        push_instr(4'hF, 1'b0, 1'b0, "halt_op");
        drain();
        restart_from_halt(1'b0, "halt_op");
        push_instr(4'h3, 1'b0, 1'b0, "after_halt"); drain();
    endtask

    task automatic test_reset_mid();
        push_instr(4'h2, 1'b0, 1'b0, "sub_rst");
        exp_q.pop_back();
        lbl_q.pop_back();
        check_one(); tick();
        check_one(); tick();
        check_one();
        #1 rst = 1'b1;
        #1;
        push(15'd0, "sub_rst.async_drop");
        check_one();
        @(negedge clk);
        push(15'd0, "sub_rst.held");
        check_one();
        rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        push_instr(4'h5, 1'b0, 1'b0, "after_rst"); drain();
    endtask

`ifdef CTRL_MEM_WAIT_EN
    task automatic test_mem_wait();
        opcode = 4'h0;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(mk(3'd1, 0, 0, 0, 0, 0, 3'd0, 1, 0, 0, 0), $sformatf("wait.fetch%0d", i));
            check_one();
            tick();
        end
        mem_ready = 1'b1;
        push(mk(3'd1, 1, 1, 0, 0, 0, 3'd0, 1, 0, 0, 0), "wait.fetch_ready");
        check_one();
        tick();
        push(mk(3'd2, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0), "wait.decode");
        check_one();
        tick();
        opcode = 4'h7;
        push(mk(3'd1, 1, 1, 0, 0, 0, 3'd0, 1, 0, 0, 0), "wait.st_fetch");
        push(mk(3'd2, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0), "wait.st_decode");
        drain();
        mem_ready = 1'b0;
        push(mk(3'd4, 0, 0, 0, 0, 0, 3'd0, 0, 1, 0, 0), "wait.st_mem_stall");
        check_one();
        tick();
        mem_ready = 1'b1;
        push(mk(3'd4, 0, 0, 0, 0, 0, 3'd0, 0, 1, 0, 0), "wait.st_mem_ready");
        check_one();
        tick();
        push_instr(4'h1, 1'b0, 1'b0, "wait.after"); drain();
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_alu();
        test_branch();
        test_load_store();
        test_back_to_back_start_ignored();
        test_illegal();
        test_halt();
        test_reset_mid();
`ifdef CTRL_MEM_WAIT_EN
        test_mem_wait();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
